// File: rtl/bm_seq_ctrl_pkg.sv
// Shared types and constants for the Berlekamp-Massey sequencer.
// Holds the FSM encoding, default code parameters and a ceil-log2 helper.
package bm_seq_ctrl_pkg;

   localparam int M_DEF = 13;
   localparam int T_DEF = 128;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      START   = 2'd1,
      RUN     = 2'd2,
      CAPTURE = 2'd3
   } state_t;

   // Width needed to hold values 0..v-1 (minimum 1 bit).
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/bm_seq_ctrl_synd_port_arb.sv
// Syndrome memory read-port arbiter: BM has strict priority over the external reader.
// ext_rd_dvalid marks memory q as external data one cycle after a grant.
module synd_port_arb
   import bm_seq_ctrl_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              bm_rd_en,
   input  logic [ADDR_W-1:0] bm_rd_addr,
   input  logic              ext_rd_req,
   input  logic [ADDR_W-1:0] ext_rd_addr,
   output logic              mem_rden,
   output logic [ADDR_W-1:0] mem_rdaddr,
   output logic              ext_rd_gnt,
   output logic              ext_rd_dvalid
);

   always_comb begin
      ext_rd_gnt = ext_rd_req & ~bm_rd_en;
      mem_rden   = bm_rd_en | ext_rd_gnt;
      mem_rdaddr = '0;
      if (bm_rd_en)
         mem_rdaddr = bm_rd_addr;
      else if (ext_rd_req)
         mem_rdaddr = ext_rd_addr;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         ext_rd_dvalid <= 1'b0;
      else
         ext_rd_dvalid <= ext_rd_gnt;
   end

endmodule

// File: rtl/bm_seq_ctrl.sv
// Sequences one BM run per syndrome block, captures the locator polynomial,
// hands it downstream via valid/ready and watches for a BM run that never finishes.
module bm_seq_ctrl
   import bm_seq_ctrl_pkg::*;
#(
   parameter  int m       = M_DEF,
   parameter  int t       = T_DEF,
   parameter  int TIMEOUT = 40000,
   localparam int ADDR_W  = clog2(2*t),
   localparam int PW      = m*(t+1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              synd_valid,
   output logic              synd_release,
   output logic              bm_start,
   input  logic              bm_synd_rd_en,
   input  logic [ADDR_W-1:0] bm_synd_rd_addr,
   input  logic              bm_done,
   input  logic [PW-1:0]     bm_error_loc_poly,
   output logic              mem_rden,
   output logic [ADDR_W-1:0] mem_rdaddr,
   input  logic              ext_rd_req,
   input  logic [ADDR_W-1:0] ext_rd_addr,
   output logic              ext_rd_gnt,
   output logic              ext_rd_dvalid,
   output logic [PW-1:0]     poly_out,
   output logic              poly_valid,
   input  logic              poly_ready,
   output logic              busy,
   output logic              timeout_err
);

   localparam int WD_W = clog2(TIMEOUT+1);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);
   localparam logic [WD_W-1:0] WD_HIT = WD_W'(TIMEOUT-1);

   state_t          state, state_nxt;
   logic [WD_W-1:0] wd;
   logic            done_q;
   logic            done_rise;
   logic            wd_hit;

   assign done_rise = bm_done & ~done_q;
   assign wd_hit    = (wd == WD_HIT);

   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // A pending undelivered polynomial holds off the next run.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (synd_valid && !poly_valid) state_nxt = START;
         START:   state_nxt = RUN;
         RUN:     if (done_rise)   state_nxt = CAPTURE;
                  else if (wd_hit) state_nxt = IDLE;
         CAPTURE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bm_start     = (state == START);
      busy         = (state != IDLE);
      synd_release = (state == CAPTURE) || ((state == RUN) && !done_rise && wd_hit);
   end

   // Edge detector is preloaded at START so a done left high by the previous run is ignored.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wd          <= '0;
         done_q      <= 1'b0;
         timeout_err <= 1'b0;
         poly_out    <= '0;
         poly_valid  <= 1'b0;
      end else begin
         if (state == START) begin
            wd     <= '0;
            done_q <= bm_done;
         end else if (state == RUN) begin
            done_q <= bm_done;
            if (wd != WD_MAX) wd <= wd + 1'b1;
            if (!done_rise && wd_hit) timeout_err <= 1'b1;
         end
         if (state == CAPTURE) begin
            poly_out   <= bm_error_loc_poly;
            poly_valid <= 1'b1;
         end else if (poly_valid && poly_ready) begin
            poly_valid <= 1'b0;
         end
      end
   end

   synd_port_arb #(.ADDR_W(ADDR_W)) u_arb (
      .clk           (clk),
      .rst_n         (rst_n),
      .bm_rd_en      (bm_synd_rd_en),
      .bm_rd_addr    (bm_synd_rd_addr),
      .ext_rd_req    (ext_rd_req),
      .ext_rd_addr   (ext_rd_addr),
      .mem_rden      (mem_rden),
      .mem_rdaddr    (mem_rdaddr),
      .ext_rd_gnt    (ext_rd_gnt),
      .ext_rd_dvalid (ext_rd_dvalid)
   );

endmodule

// File: doc/bm_seq_ctrl.md
Name: bm_seq_ctrl

Overview:
- Sequences one Berlekamp-Massey run per syndrome block and owns the single read port of the 2t-deep syndrome memory.
- Arbitrates that port between BM and an external reader (debug/readback). BM has strict priority.
- Captures the error-locator polynomial into a holding register and hands it downstream with a valid/ready handshake.
- Runs a watchdog that flags a BM run which never raises done.

Parameters:
m, 13, GF(2^m) element width (syndrome word width)
t, 128, error-correction capability; syndrome memory depth is 2*t
TIMEOUT, 40000, maximum cycles from bm_start to bm_done before error
ADDR_W, CLOG2(2*t), syndrome address width (derived, not overridden)

Ports:
clk  in  1  clock, all logic rising-edge
rst_n  in  1  synchronous active-low reset
synd_valid  in  1  syndrome memory holds a complete new block (level)
synd_release  out  1  one-cycle pulse: syndrome memory may be overwritten
bm_start  out  1  one-cycle start pulse to BM
bm_synd_rd_en  in  1  BM read enable
bm_synd_rd_addr  in  ADDR_W  BM read address
bm_done  in  1  BM done (pulse or level; rising edge used)
bm_error_loc_poly  in  m*(t+1)  BM result
mem_rden  out  1  syndrome memory read enable
mem_rdaddr  out  ADDR_W  syndrome memory read address
ext_rd_req  in  1  external read request
ext_rd_addr  in  ADDR_W  external read address
ext_rd_gnt  out  1  external request granted this cycle
ext_rd_dvalid  out  1  memory q is external data (one cycle after grant)
poly_out  out  m*(t+1)  captured polynomial
poly_valid  out  1  poly_out valid
poly_ready  in  1  downstream accepts poly_out
busy  out  1  state != IDLE
timeout_err  out  1  sticky watchdog error, cleared by reset only

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE.
  - All outputs 0: poly_out, counters, timeout_err. mem_rdaddr 0.
  - Reset mid-run abandons BM. BM has no reset, so the next bm_start must restart it.
- States and transitions:
  - IDLE: go to START when synd_valid=1 and poly_valid=0. A pending undelivered polynomial blocks a new run.
  - START: bm_start=1 for exactly one cycle. Clear watchdog. Go to RUN.
  - RUN: watchdog increments each cycle. On bm_done rising edge (registered previous value), go to CAPTURE. If watchdog reaches TIMEOUT-1 with no done, set timeout_err and go to IDLE; no capture, synd_release still pulses.
  - CAPTURE: poly_out <= bm_error_loc_poly, poly_valid <= 1, synd_release pulses for one cycle. Go to IDLE.
- bm_done already high in START is not treated as a rising edge. The edge detector is preloaded with bm_done at START, which avoids stale done from the previous run.
- Handshake: poly_valid stays high with poly_out stable until a cycle with poly_valid & poly_ready, then drops next cycle. If synd_valid is high in that same cycle, START is entered no earlier than the following cycle.
- Arbitration is combinational on mem_rden/mem_rdaddr:
  - bm_synd_rd_en=1: BM address drives the port, ext_rd_gnt=0.
  - Otherwise ext_rd_req=1: ext_rd_gnt=1 and ext_rd_addr drives the port.
  - mem_rden = bm_synd_rd_en | ext_rd_gnt.
  - ext_rd_dvalid = ext_rd_gnt registered (memory latency 1).
  - Simultaneous requests: BM wins. The external requester holds its request until granted.
  - External reads are allowed in any state.
- Widths: watchdog is CLOG2(TIMEOUT+1) bits and saturates (never wraps). Address widths are passed through unchanged.
- Out-of-range address (>= 2*t) is not checked here; the memory is responsible.

Decomposition:
- Shared package/header: CLOG2 macro, state encodings (IDLE/START/RUN/CAPTURE), default m/t constants.
- One natural sub-module, synd_port_arb: combinational priority mux plus the dvalid register.

Test Plan:
1. m=13, t=4, BM model reading 8 syndromes and raising done after 50 cycles; synd_valid=1, poly_ready=1 -> bm_start one cycle after IDLE exit, poly_valid 2 cycles after done with poly_out equal to the model's poly, synd_release one pulse.
2. poly_ready=0 for 20 cycles after capture while synd_valid stays 1 -> no second bm_start until the handshake completes; poly_out unchanged throughout.
3. BM reads addr 3 while ext requests addr 5 in the same cycle -> mem_rdaddr=3, ext_rd_gnt=0. Next idle cycle -> gnt=1, addr 5, ext_rd_dvalid=1 one cycle later.
4. TIMEOUT=100, BM never asserts done -> timeout_err=1 at cycle 100 after start, state IDLE, poly_valid stays 0, synd_release pulses.
5. rst_n=0 during RUN -> next cycle busy=0, all outputs 0. A fresh run after reset completes normally (stale done high at START is ignored).
6. Two back-to-back blocks mirroring a double-start sequence -> two bm_start pulses, two captures, both polynomials delivered in order.
